nibble_load_arbiter: RTL and testbench
======================================

Name: nibble_load_arbiter

Overview:
- Shares the write port of a small bank of 4-bit destination registers (v1/v2-style `logic` holders) between several source requesters (constant-driven nets, procedurally written regs).
- Arbitrates requests round-robin, one write per cycle.
- Enforces a per-destination hold-off after each write.
- Exposes destination contents plus "written since reset" flags to downstream checkers.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_DST, 2, number of destination registers (>=2).
- DATA_W, 4, data width per requester and destination.
- HOLD_CYC, 1, cycles a destination stays locked after a write (0 = no lockout).
- DST_W, $clog2(NUM_DST), destination index width (derived, localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_dst  input  NUM_REQ*DST_W  per-requester destination index; slice i belongs to requester i.
- req_data  input  NUM_REQ*DATA_W  per-requester write data.
- req_ready  output  NUM_REQ  one-hot grant, combinational, same cycle.
- dst_q  output  NUM_DST*DATA_W  destination register contents.
- dst_written  output  NUM_DST  destination written at least once since reset.
- grant_vld  output  1  registered: a write happened last cycle.
- grant_id  output  $clog2(NUM_REQ)  registered: requester index of last write.

Behaviour:
- Reset (asynchronous, active-high) clears all state immediately:
  - dst_q = 0, dst_written = 0.
  - rr_ptr = 0, all busy counters = 0.
  - grant_vld = 0, grant_id = 0.
- While rst is high, req_ready = 0.
- Reset mid-lockout clears the lockout. No write completes on an edge where rst is high.
- Busy: destination d is busy when busy_cnt[d] != 0.
- Eligible requester: i is eligible when req_valid[i]=1, req_dst[i] < NUM_DST, and req_dst[i] is not busy.
- Out-of-range req_dst: the requester is never granted. It stalls indefinitely, with no error flag.
- Arbitration:
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready has at most one bit set, and only for the winner.
  - Handshake completes when req_valid & req_ready are both 1 in the same cycle.
- On the handshake edge:
  - dst_q[req_dst] <= req_data; dst_written[req_dst] <= 1.
  - busy_cnt[req_dst] <= HOLD_CYC.
  - rr_ptr <= winner+1, wrapping NUM_REQ-1 -> 0.
  - grant_vld <= 1; grant_id <= winner.
- Cycle with no handshake: grant_vld <= 0; grant_id and rr_ptr hold.
- Busy counters: each non-zero busy_cnt decrements by 1 per cycle. A fresh write reloads the counter; reload has priority over decrement.
- Lockout timing: with HOLD_CYC=H, the next write to the same destination is possible H+1 cycles after the previous one.
- Latency: a write is visible on dst_q one edge after the handshake.
- Parallel destinations: writes to different non-busy destinations in consecutive cycles are allowed. Throughput is 1 write/cycle total.
- Contention: requesters targeting the same destination are serialized in round-robin order.
- Deassertion: a requester may drop req_valid before it is granted; no state is retained for it.
- Width: req_data is stored bit-exact, with no extension or truncation (DATA_W in = DATA_W out).

Decomposition:
- Shared package nibble_pkg:
  - DATA_W default constant.
  - typedef nibble_t = logic [DATA_W-1:0].
  - idx_w(n) function returning $clog2(n).
- Sub-module rr_pick:
  - Parameterized NUM_REQ.
  - Purely combinational: inputs eligible mask and rr_ptr; outputs one-hot grant and encoded winner index.
  - Instantiated once; the top level holds the pointer, busy counters and destination registers.

Test Plan:
- Reset check: assert rst async mid-cycle -> dst_q=0, dst_written=00, grant_vld=0 immediately. Release rst, one idle cycle -> still 0.
- Single writes, HOLD_CYC=1:
  - Cycle 0: req0 (dst0, 4'b0011). Cycle 1: req1 (dst1, 4'b0111).
  - Expect dst_q = {0111,0011}, dst_written=11, grant_id 0 then 1.
- Overwrite: req2 writes dst0=4'b1111, then req3 writes dst1=4'b0110.
  - Expect dst_q = {0110,1111}.
  - Expect rr_ptr wraps to 0 after req3.
- Contention with lockout, HOLD_CYC=1: all 4 requesters assert continuously with dst0.
  - Expect grants 0,1,2,3 on cycles 0,2,4,6.
  - Expect no grant on odd cycles; grant_vld toggles 1,0.
- Parallel destinations: req0→dst0 and req1→dst1 held valid, HOLD_CYC=1.
  - Expect alternating grants every cycle (0,1,0,1).
  - Expect no idle cycles.
- Reset during lockout:
  - Write dst0 with HOLD_CYC=3, assert rst one cycle later, release.
  - Request dst0 on the first cycle after release -> granted immediately, dst_q[0] updated next edge.

Source files
------------

// File: rtl/nibble_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nibble_pkg : shared widths, nibble type and index-width helper
// Revision   : 1.0
// ---------------------------------------------------------------------------
package nibble_pkg;

  localparam int DEF_DATA_W = 4;

  typedef logic [DEF_DATA_W-1:0] nibble_t;

  // Never returns 0 so that a 1-entry index still gets a real 1-bit vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_load_arbiter_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker over an eligibility mask
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_pick
  import nibble_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      win_o,
  output logic               any_o
);

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan from the far end back toward ptr so the closest eligible slot wins.
  always_comb begin
    grant_o = '0;
    win_o   = '0;
    any_o   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_i[slot(ptr_i, k)]) begin
        win_o = slot(ptr_i, k);
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[win_o] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/nibble_load_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nibble_load_arbiter : round-robin write port sharing with per-dst hold-off
// Revision            : 1.0
// ---------------------------------------------------------------------------
module nibble_load_arbiter
  import nibble_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_DST  = 2,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int HOLD_CYC = 1,
  localparam int DST_W    = idx_w(NUM_DST),
  localparam int REQ_W    = idx_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DST_W-1:0]    req_dst,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_DST*DATA_W-1:0]   dst_q,
  output logic [NUM_DST-1:0]          dst_written,
  output logic                        grant_vld,
  output logic [REQ_W-1:0]            grant_id
);

  localparam int               CNT_W   = idx_w(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);

  logic [REQ_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]               grant_id_q;
  logic                           grant_vld_q;
  logic [NUM_DST-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_DST-1:0]             written_q, written_d;
  logic [CNT_W-1:0]               busy_q [NUM_DST];
  logic [CNT_W-1:0]               busy_d [NUM_DST];
  logic [NUM_DST-1:0]             busy;
  logic [NUM_REQ-1:0]             elig, grant;
  logic [REQ_W-1:0]               win;
  logic                           any;
  logic [DST_W-1:0]               win_dst;
  logic [DATA_W-1:0]              win_data;

  generate
    for (genvar d = 0; d < NUM_DST; d++) begin : g_busy
      assign busy[d] = (busy_q[d] != '0);
    end
  endgenerate

  // Matching against each real destination drops out-of-range indices naturally.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (int'(req_dst[i*DST_W +: DST_W]) == d && !busy[d])
          elig[i] = req_valid[i];
      end
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .win_o   (win),
    .any_o   (any)
  );

  assign req_ready = rst ? '0 : grant;
  assign win_dst   = req_dst[int'(win)*DST_W +: DST_W];
  assign win_data  = req_data[int'(win)*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    written_d = written_q;
    for (int d = 0; d < NUM_DST; d++)
      busy_d[d] = busy[d] ? busy_q[d] - CNT_W'(1) : '0;
    if (any) begin
      rr_ptr_d          = (int'(win) == NUM_REQ - 1) ? '0 : win + REQ_W'(1);
      data_d[win_dst]   = win_data;
      written_d[win_dst] = 1'b1;
      busy_d[win_dst]   = HOLD_LD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      grant_vld_q <= 1'b0;
      data_q      <= '0;
      written_q   <= '0;
      for (int d = 0; d < NUM_DST; d++) busy_q[d] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_vld_q <= any;
      if (any) grant_id_q <= win;
      data_q      <= data_d;
      written_q   <= written_d;
      for (int d = 0; d < NUM_DST; d++) busy_q[d] <= busy_d[d];
    end
  end

  assign dst_q       = data_q;
  assign dst_written = written_q;
  assign grant_vld   = grant_vld_q;
  assign grant_id    = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_load_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nibble_load_arbiter : two configurations against a timestamp-based model
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_nibble_load_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_valid = '0;
  logic [3:0]  dst_a     = '0;
  logic [7:0]  dst_b     = '0;
  logic [15:0] req_data  = '0;
  logic [3:0]  rdy_a, rdy_b;
  logic [7:0]  q_a;
  logic [11:0] q_b;
  logic [1:0]  wr_a;
  logic [2:0]  wr_b;
  logic        gv_a, gv_b;
  logic [1:0]  gid_a, gid_b;

  // A: 2 destinations, hold 1.  B: 3 destinations (index 3 out of range), hold 3.
  nibble_load_arbiter #(.NUM_REQ(4), .NUM_DST(2), .DATA_W(4), .HOLD_CYC(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dst(dst_a), .req_data(req_data),
    .req_ready(rdy_a), .dst_q(q_a), .dst_written(wr_a), .grant_vld(gv_a), .grant_id(gid_a));

  nibble_load_arbiter #(.NUM_REQ(4), .NUM_DST(3), .DATA_W(4), .HOLD_CYC(3)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dst(dst_b), .req_data(req_data),
    .req_ready(rdy_b), .dst_q(q_b), .dst_written(wr_b), .grant_vld(gv_b), .grant_id(gid_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each destination remembers the first cycle at which it may be written again.
  int         m_next_ok [2][4];
  logic [3:0] m_data    [2][4];
  bit         m_wr      [2][4];
  int         m_ptr     [2];
  bit         m_gv      [2];
  int         m_gid     [2];
  int         cyc = 0;

  bit [3:0]   s_valid;
  int         s_dst  [2][4];
  logic [3:0] s_data [4];
  logic [3:0] last_rdy_a, last_rdy_b;

  function automatic int hold_of(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int ndst_of(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 4; d++) begin
        m_next_ok[m][d] = 0;
        m_data[m][d]    = '0;
        m_wr[m][d]      = 1'b0;
      end
      m_ptr[m] = 0;
      m_gv[m]  = 1'b0;
      m_gid[m] = 0;
    end
  endfunction

  function automatic int model_pick(input int m);
    for (int k = 0; k < 4; k++) begin
      int i, d;
      i = (m_ptr[m] + k) % 4;
      d = s_dst[m][i];
      if (s_valid[i] && d < ndst_of(m) && cyc >= m_next_ok[m][d]) return i;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = s_valid[i];
      dst_a[i]            = s_dst[0][i][0];
      dst_b[i*2 +: 2]     = s_dst[1][i][1:0];
      req_data[i*4 +: 4]  = s_data[i];
    end
  endtask

  task automatic check_state();
    logic [31:0] eq, ew;
    for (int m = 0; m < 2; m++) begin
      eq = '0;
      ew = '0;
      for (int d = 0; d < ndst_of(m); d++) begin
        eq[d*4 +: 4] = m_data[m][d];
        ew[d]        = m_wr[m][d];
      end
      if (m == 0) begin
        check_eq("A.dst_q", 32'(q_a), eq);
        check_eq("A.written", 32'(wr_a), ew);
        check_eq("A.grant_vld", 32'(gv_a), 32'(m_gv[0]));
        check_eq("A.grant_id", 32'(gid_a), 32'(m_gid[0]));
      end else begin
        check_eq("B.dst_q", 32'(q_b), eq);
        check_eq("B.written", 32'(wr_b), ew);
        check_eq("B.grant_vld", 32'(gv_b), 32'(m_gv[1]));
        check_eq("B.grant_id", 32'(gid_b), 32'(m_gid[1]));
      end
    end
  endtask

  task automatic run_cycle();
    int w [2];
    @(negedge clk);
    apply();
    #1;
    for (int m = 0; m < 2; m++) w[m] = model_pick(m);
    last_rdy_a = rdy_a;
    last_rdy_b = rdy_b;
    check_eq("A.ready", 32'(rdy_a), (w[0] < 0) ? 32'd0 : (32'd1 << w[0]));
    check_eq("B.ready", 32'(rdy_b), (w[1] < 0) ? 32'd0 : (32'd1 << w[1]));
    check_state();
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (w[m] >= 0) begin
        int d;
        d = s_dst[m][w[m]];
        m_data[m][d]    = s_data[w[m]];
        m_wr[m][d]      = 1'b1;
        m_next_ok[m][d] = cyc + hold_of(m) + 1;
        m_ptr[m]        = (w[m] + 1) % 4;
        m_gv[m]         = 1'b1;
        m_gid[m]        = w[m];
      end else begin
        m_gv[m] = 1'b0;
      end
    end
    cyc++;
  endtask

  // Asserted off-edge with every requester valid, so ready must be masked by rst alone.
  task automatic async_reset();
    @(negedge clk);
    s_valid = '1;
    apply();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst.ready_a", 32'(rdy_a), 32'd0);
    check_eq("rst.ready_b", 32'(rdy_b), 32'd0);
    check_state();
    @(posedge clk);
    @(negedge clk);
    s_valid = '0;
    apply();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input int da, input int db, input logic [3:0] data);
    s_valid[i]  = 1'b1;
    s_dst[0][i] = da;
    s_dst[1][i] = db;
    s_data[i]   = data;
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    repeat (n) run_cycle();
  endtask

  initial begin
    s_valid = '0;
    for (int i = 0; i < 4; i++) begin
      s_dst[0][i] = 0;
      s_dst[1][i] = 0;
      s_data[i]   = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    async_reset();
    idle(1);

    // Single writes then overwrite; the pointer wraps back to 0 after requester 3.
    s_valid = '0; set_req(0, 0, 0, 4'b0011); run_cycle();
    s_valid = '0; set_req(1, 1, 1, 4'b0111); run_cycle();
    #2;
    check_eq("single.dst_q", 32'(q_a), 32'h73);
    check_eq("single.written", 32'(wr_a), 32'h3);
    check_eq("single.grant_id", 32'(gid_a), 32'd1);
    idle(4);
    s_valid = '0; set_req(2, 0, 0, 4'b1111); run_cycle();
    s_valid = '0; set_req(3, 1, 1, 4'b0110); run_cycle();
    #2;
    check_eq("overwrite.dst_q", 32'(q_a), 32'h6F);
    idle(4);

    // Everyone on destination 0: one grant every other cycle on A.
    for (int i = 0; i < 4; i++) set_req(i, 0, 0, 4'(i + 8));
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      check_eq("contend.ready", 32'(last_rdy_a), (k % 2 == 0) ? (32'd1 << (k / 2)) : 32'd0);
    end
    idle(4);

    // Two requesters on distinct destinations: back-to-back alternating grants.
    set_req(0, 0, 0, 4'h5);
    set_req(1, 1, 1, 4'hA);
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      check_eq("parallel.ready", 32'(last_rdy_a), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(4);

    // Reset during B's 3-cycle lockout must free destination 0 at once.
    s_valid = '0; set_req(0, 0, 0, 4'h9); run_cycle();
    async_reset();
    s_valid = '0; set_req(0, 0, 0, 4'hC); run_cycle();
    check_eq("lockrst.ready_b", 32'(last_rdy_b), 32'd1);
    #2;
    check_eq("lockrst.dst_q_b", 32'(q_b[3:0]), 32'hC);
    idle(1);

    // Random traffic with sticky requests and occasional resets.
    for (int n = 0; n < 450; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          s_valid[i]  = ($urandom_range(0, 2) != 0);
          s_dst[0][i] = int'($urandom_range(0, 1));
          s_dst[1][i] = int'($urandom_range(0, 3));
          s_data[i]   = 4'($urandom);
        end
      end
      run_cycle();
      if (n % 150 == 149) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
